// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, FSM state encoding and bit-timing helpers
package uart_pkg;
  localparam int DEF_CLK_FREQ = 50_000_000;
  localparam int DEF_BAUD = 9600;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  function automatic int bit_cycles(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction
  function automatic int half_cycles(input int clk_freq, input int baud);
    return bit_cycles(clk_freq, baud) / 2;
  endfunction
endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period counter with half-bit and full-bit ticks
//   clk, rst_n   : clock, async active-low reset
//   i_clear      : restart the count from 0 on the next edge
//   o_half_tick  : high on the last cycle of a half bit period
//   o_full_tick  : high on the last cycle of a full bit period (count wraps)
module uart_baud_cnt #(
  parameter int BIT_CYCLES = 5208,
  parameter int HALF_CYCLES = 2604
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  output logic o_half_tick,
  output logic o_full_tick
);
  localparam int W = $clog2(BIT_CYCLES);
  logic [W-1:0] r_cnt;
  assign o_half_tick = r_cnt == W'(HALF_CYCLES - 1);
  assign o_full_tick = r_cnt == W'(BIT_CYCLES - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else r_cnt <= (i_clear || o_full_tick) ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8-bit UART receiver, LSB-first, optional even parity (UART_RX_PARITY_EN)
//   clk, rst_n : clock, async active-low reset
//   rx         : serial line, idles high
//   rx_data    : last received byte       rx_valid : unconsumed byte present
//   rx_ack     : consumer pulse           parity_err/frame_err : status of rx_data
//   overrun    : sticky, byte lost        busy : FSM not in IDLE
module uart_rx import uart_pkg::*; #(
  parameter int CLK_FREQ = DEF_CLK_FREQ,
  parameter int BAUD = DEF_BAUD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);
  localparam int BITC = bit_cycles(CLK_FREQ, BAUD);
  localparam int HALFC = half_cycles(CLK_FREQ, BAUD);
  state_t r_state, w_nxt;
  logic [1:0] r_sync;
  logic r_prev, r_stop, r_done;
  logic [7:0] r_shift;
  logic [2:0] r_idx;
  logic w_rx, w_half, w_full, w_clr, w_shift, w_stop;
`ifdef UART_RX_PARITY_EN
  logic r_par, r_perr, w_par;
  assign parity_err = r_perr;
`else
  assign parity_err = 1'b0;
`endif
  assign w_rx = r_sync[1];
  assign busy = r_state != IDLE;
  uart_baud_cnt #(.BIT_CYCLES(BITC), .HALF_CYCLES(HALFC)) u_cnt (
    .clk(clk), .rst_n(rst_n), .i_clear(w_clr), .o_half_tick(w_half), .o_full_tick(w_full)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_nxt;
  // counter is held at 0 in IDLE and restarted after the start-bit centre,
  // so every later full tick lands on a bit centre
  always_comb begin
    w_nxt = r_state;
    w_clr = 1'b0;
    w_shift = 1'b0;
    w_stop = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        w_clr = 1'b1;
        if (r_prev && !w_rx) w_nxt = START;
      end
      START: if (w_half) begin
        w_clr = 1'b1;
        w_nxt = w_rx ? IDLE : DATA;
      end
      DATA: if (w_full) begin
        w_shift = 1'b1;
`ifdef UART_RX_PARITY_EN
        if (r_idx == 3'd7) w_nxt = PARITY;
`else
        if (r_idx == 3'd7) w_nxt = STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (w_full) begin
        w_par = 1'b1;
        w_nxt = STOP;
      end
`endif
      STOP: if (w_full) begin
        w_stop = 1'b1;
        w_nxt = IDLE;
      end
      default: w_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_sync <= 2'b11;
      r_prev <= 1'b1;
      r_shift <= '0;
      r_idx <= '0;
      r_stop <= 1'b0;
      r_done <= 1'b0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], rx};
      r_prev <= w_rx;
      r_done <= w_stop;
      if (w_shift) begin
        r_shift <= {w_rx, r_shift[7:1]};
        r_idx <= r_idx + 1'b1;
      end
      if (w_stop) r_stop <= w_rx;
      // a completion beats a coincident ack; only an unacked completion overruns
      rx_valid <= r_done || (rx_valid && !rx_ack);
      if (r_done) begin
        rx_data <= r_shift;
        frame_err <= !r_stop;
        if (rx_valid && !rx_ack) overrun <= 1'b1;
      end
    end
`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_par <= 1'b0;
      r_perr <= 1'b0;
    end else begin
      if (w_par) r_par <= w_rx;
      if (r_done) r_perr <= ^r_shift ^ r_par;
    end
`endif
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against uart_rx with a short bit time
module tb_uart_rx;
  localparam int CLK_FREQ = 3_200_000;
  localparam int BAUD = 100_000;
  localparam int BITC = CLK_FREQ / BAUD;
  localparam int HALF = BITC / 2;
`ifdef UART_RX_PARITY_EN
  localparam bit PE = 1'b1;
`else
  localparam bit PE = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, rx = 1'b1, rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic rx_valid, parity_err, frame_err, overrun, busy;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
    .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input bit ack_done, input int rst_at);
    logic [10:0] bits;
    int n;
    bit acked;
    acked = 1'b0;
    bits = PE ? {s, p, d, 1'b0} : {1'b0, s, d, 1'b0};
    n = PE ? 11 : 10;
    for (int b = 0; b < n; b++)
      for (int c = 0; c < BITC; c++) begin
        @(negedge clk);
        rx = bits[b];
        rx_ack = 1'b0;
        if (b == rst_at && c == HALF) begin
          rst_n = 1'b0;
          repeat (3) @(negedge clk);
          rx = 1'b1;
          rst_n = 1'b1;
          repeat (8) @(negedge clk);
          return;
        end
        if (ack_done && b == n - 1 && !busy && !acked) begin
          rx_ack = 1'b1;
          acked = 1'b1;
        end
      end
    @(negedge clk);
    rx = 1'b1;
    rx_ack = 1'b0;
    repeat (8) @(negedge clk);
  endtask
  task automatic ack_pulse();
    @(negedge clk);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("rst_data", rx_data, 8'h00);
    check("rst_valid", 8'(rx_valid), 8'd0);
    check("rst_perr", 8'(parity_err), 8'd0);
    check("rst_ferr", 8'(frame_err), 8'd0);
    check("rst_ovr", 8'(overrun), 8'd0);
    check("rst_busy", 8'(busy), 8'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    send_frame(8'h0C, 1'b0, 1'b1, 1'b0, -1);
    check("f0c_data", rx_data, 8'h0C);
    check("f0c_valid", 8'(rx_valid), 8'd1);
    check("f0c_perr", 8'(parity_err), 8'd0);
    check("f0c_ferr", 8'(frame_err), 8'd0);
    check("f0c_busy", 8'(busy), 8'd0);
    ack_pulse();
    check("ack_clr", 8'(rx_valid), 8'd0);
    ack_pulse();
    check("ack_idle", 8'(rx_valid), 8'd0);
    send_frame(8'h0E, 1'b0, 1'b1, 1'b0, -1);
    check("f0e_data", rx_data, 8'h0E);
    check("f0e_perr", 8'(parity_err), PE ? 8'd1 : 8'd0);
    ack_pulse();
    send_frame(8'h03, 1'b0, 1'b1, 1'b0, -1);
    check("f03_data", rx_data, 8'h03);
    check("f03_perr", 8'(parity_err), 8'd0);
    ack_pulse();
    @(negedge clk);
    rx = 1'b0;
    for (int c = 1; c <= HALF + 4; c++) begin
      @(negedge clk);
      if (c == HALF / 2) rx = 1'b1;
      if (c == 5) check("fs_busy_hi", 8'(busy), 8'd1);
    end
    check("fs_busy_lo", 8'(busy), 8'd0);
    check("fs_valid", 8'(rx_valid), 8'd0);
    check("fs_data", rx_data, 8'h03);
    repeat (8) @(negedge clk);
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, -1);
    check("f55_data", rx_data, 8'h55);
    check("f55_ferr", 8'(frame_err), 8'd1);
    check("f55_valid", 8'(rx_valid), 8'd1);
    check("f55_perr", 8'(parity_err), 8'd0);
    ack_pulse();
    send_frame(8'h0C, 1'b0, 1'b1, 1'b0, -1);
    check("ovr_first", 8'(overrun), 8'd0);
    check("ovr_ferr_clr", 8'(frame_err), 8'd0);
    send_frame(8'h03, 1'b0, 1'b1, 1'b0, -1);
    check("ovr_data", rx_data, 8'h03);
    check("ovr_set", 8'(overrun), 8'd1);
    check("ovr_valid", 8'(rx_valid), 8'd1);
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 5);
    check("mid_data", rx_data, 8'h00);
    check("mid_valid", 8'(rx_valid), 8'd0);
    check("mid_ovr", 8'(overrun), 8'd0);
    check("mid_busy", 8'(busy), 8'd0);
    check("mid_ferr", 8'(frame_err), 8'd0);
    send_frame(8'h0C, 1'b0, 1'b1, 1'b0, -1);
    check("post_data", rx_data, 8'h0C);
    check("post_valid", 8'(rx_valid), 8'd1);
    check("post_perr", 8'(parity_err), 8'd0);
    send_frame(8'h03, 1'b0, 1'b1, 1'b1, -1);
    check("coin_data", rx_data, 8'h03);
    check("coin_valid", 8'(rx_valid), 8'd1);
    check("coin_ovr", 8'(overrun), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, meaning the input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, meaning the serial bit rate.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n, input, 1, the reset; it is asynchronous and active-low.
REQ-005 SHALL have port rx, input, 1, the asynchronous serial line; it idles high.
REQ-006 SHALL have port rx_data, output, 8, the last received byte, LSB-first on the line.
REQ-007 SHALL have port rx_valid, output, 1, meaning rx_data holds an unconsumed byte.
REQ-008 SHALL have port rx_ack, input, 1, the consumer pulse that clears rx_valid.
REQ-009 SHALL have port parity_err, output, 1, the even-parity mismatch for the current byte.
REQ-010 SHALL have port frame_err, output, 1, meaning the stop bit was sampled low for the current byte.
REQ-011 SHALL have port overrun, output, 1, sticky; a byte completed while rx_valid=1.
REQ-012 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-013 SHALL pass rx through a 2-flop synchronizer reset to 1; all decoding uses the synchronized value.
REQ-014 SHALL define BIT_CYCLES = CLK_FREQ/BAUD (integer division; 5208 at defaults) and HALF_CYCLES = BIT_CYCLES/2 (2604).
REQ-015 SHALL implement the FSM IDLE->START->DATA->PARITY->STOP->IDLE, driven by one bit-period counter.
REQ-016 In IDLE, a synchronized falling edge (1 then 0) SHALL clear the counter and enter START.
REQ-017 In START, at HALF_CYCLES the line SHALL be resampled; if it is high (false start), the FSM returns to IDLE with no output change.
REQ-018 After a valid start, each of the 8 data bits SHALL be sampled every BIT_CYCLES thereafter (bit centre) and shifted in LSB-first; a 3-bit index wraps 7->0 on exit from DATA.
REQ-019 PARITY SHALL sample one bit; parity_err = (XOR of data bits) XOR sampled bit, which is 0 for even parity.
REQ-020 STOP SHALL sample at bit centre; frame_err = ~sample; the FSM returns to IDLE immediately after the sample, without waiting for the full stop bit.
REQ-021 One cycle after the stop sample, rx_data, parity_err and frame_err SHALL update together and rx_valid SHALL set; bytes with errors are still delivered.
REQ-022 rx_ack while rx_valid=1 SHALL clear rx_valid on the next edge; rx_ack with rx_valid=0 SHALL be ignored.
REQ-023 If a byte completes while rx_valid=1 and rx_ack is low, rx_data SHALL be overwritten, rx_valid stays 1, and overrun sets; overrun clears only on reset.
REQ-024 If a completion and rx_ack coincide, the new byte SHALL win: rx_valid stays 1 and overrun does not set.

Reset
REQ-025 rst_n low SHALL asynchronously force: state IDLE, counters 0, synchronizer 1, rx_data 0x00, and rx_valid, parity_err, frame_err, overrun and busy all 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no partial byte delivered; after release, the receiver waits for a new falling edge.

Configuration
REQ-027 Macro UART_RX_PARITY_EN defined SHALL give an 11-bit frame with the PARITY state, as above.
REQ-028 Without UART_RX_PARITY_EN, the frame SHALL be 10 bits, DATA goes directly to STOP, and parity_err is tied to 0.

Structure
REQ-029 Package uart_pkg SHALL hold the FSM state encoding, the BIT_CYCLES/HALF_CYCLES derivation and the default CLK_FREQ/BAUD constants, shared with the future transmitter.
REQ-030 Sub-module uart_baud_cnt SHALL provide the bit-period counter, with clear input and half_tick/full_tick outputs.

Verification (defaults, parity enabled, bit time 5208 clk)
REQ-031 Frame 0x0C with parity 0 and stop 1 -> rx_data=0x0C, rx_valid=1, parity_err=0, frame_err=0; rx_ack clears rx_valid next cycle.
REQ-032 Frame 0x0E with parity 0 -> rx_data=0x0E, parity_err=1; then 0x03 with parity 0 -> parity_err=0.
REQ-033 rx low for 1000 cycles then high -> no rx_valid, busy back to 0 by cycle HALF_CYCLES+3.
REQ-034 Frame 0x55 with stop bit 0 -> rx_data=0x55, frame_err=1, rx_valid=1.
REQ-035 Frames 0x0C then 0x03 sent with no rx_ack -> rx_data=0x03, overrun=1; a third byte with rx_ack coincident at completion -> overrun unchanged, rx_valid=1.
REQ-036 rst_n pulsed low during bit 4 of a frame -> all outputs 0; the next clean 0x0C frame is received correctly.
